// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR address map and read-FSM state type
package csr_pkg;

   localparam int CSR_BLK_W = 3;
   localparam int CSR_SUB_W = 3;
   localparam int CSR_NUM_BLK = 6;

   localparam logic [3:0] PWR = 4'd0;
   localparam logic [3:0] RX1 = 4'd1;
   localparam logic [3:0] RX2 = 4'd2;
   localparam logic [3:0] TX1 = 4'd3;
   localparam logic [3:0] TX2 = 4'd4;
   localparam logic [3:0] MEM = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } csr_rd_state_t;

endpackage

// File: rtl/csr_rd.sv
// rtl/csr_rd.sv - CSR read sequencer: strobe the addressed block, wait with timeout, return data or error
module csr_rd
   import csr_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   rd_req,
   input  logic [5:0]             rd_addr,
   output logic                   rd_ack,
   output logic                   rd_valid,
   output logic [7:0]             rd_data,
   output logic                   rd_err,
   output logic [CSR_NUM_BLK-1:0] blk_rd,
   output logic [CSR_SUB_W-1:0]   blk_sub_addr,
   input  logic [7:0]             blk_rdata,
   input  logic [CSR_NUM_BLK-1:0] blk_rvalid,
   output logic [7:0]             timeout_cnt
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   csr_rd_state_t          state_q, state_d;
   logic [CSR_BLK_W-1:0]   sel_q, sel_d;
   logic [CSR_SUB_W-1:0]   sub_q, sub_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             rd_data_q, rd_data_d;
   logic                   rd_err_q, rd_err_d;
   logic [7:0]             tcnt_q, tcnt_d;
   logic [CSR_NUM_BLK-1:0] sel_onehot;
   logic                   sel_hit;

   // Codes 6/7 shift out of range and give an all-zero mask; they never reach ISSUE anyway.
   assign sel_onehot = CSR_NUM_BLK'(1) << sel_q;
   assign sel_hit    = |(blk_rvalid & sel_onehot);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      sub_d     = sub_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      rd_err_d  = rd_err_q;
      tcnt_d    = tcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               sel_d = rd_addr[5:3];
               sub_d = rd_addr[2:0];
               case ({1'b0, rd_addr[5:3]})
                  PWR, RX1, RX2, TX1, TX2, MEM: state_d = ST_ISSUE;
                  default: begin
                     rd_data_d = 8'hFF;
                     rd_err_d  = 1'b1;
                     state_d   = ST_RESP;
                  end
               endcase
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A response on the last WAIT cycle is checked first, so it beats the timeout.
            if (sel_hit) begin
               rd_data_d = blk_rdata;
               rd_err_d  = 1'b0;
               state_d   = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rd_data_d = 8'hFF;
               rd_err_d  = 1'b1;
               if (tcnt_q != 8'hFF) begin
                  tcnt_d = tcnt_q + 8'd1;
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         sub_q     <= '0;
         cnt_q     <= '0;
         rd_data_q <= 8'h00;
         rd_err_q  <= 1'b0;
         tcnt_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         sub_q     <= sub_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
         tcnt_q    <= tcnt_d;
      end
   end

   // Strobe and valid decode straight from the state flop so reset drops them immediately.
   assign rd_ack       = (state_q == ST_IDLE) & rd_req;
   assign rd_valid     = (state_q == ST_RESP);
   assign blk_rd       = (state_q == ST_ISSUE) ? sel_onehot : '0;
   assign blk_sub_addr = sub_q;
   assign rd_data      = rd_data_q;
   assign rd_err       = rd_err_q;
   assign timeout_cnt  = tcnt_q;

endmodule
